// File: rtl/me_mb_sched.sv
// Macroblock sequencer for the 16x16 motion-estimation datapath: fills the
// current/reference buffers, runs the SAD core, and hands each result downstream.
module me_mb_sched #(
  parameter int CUR_ROWS     = 16,
  parameter int REF_ROWS     = 31,
  parameter int MB_PER_FRAME = 32400,
  parameter int SETTLE       = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        cur_vld,
  output logic        cur_read,
  input  logic        ref_vld,
  output logic        ref_read,
  output logic        core_rst_n,
  input  logic        sad_en,
  input  logic [13:0] sad_min,
  input  logic [3:0]  mv_x,
  input  logic [3:0]  mv_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [13:0] res_sad,
  output logic [3:0]  res_x,
  output logic [3:0]  res_y,
  output logic [14:0] mb_idx,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int CW = $clog2(CUR_ROWS + 1);
  localparam int RW = $clog2(REF_ROWS + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CUR_FULL  = CW'(CUR_ROWS);
  localparam logic [RW-1:0] REF_FULL  = RW'(REF_ROWS);
  localparam logic [SW-1:0] SETTLE_C  = SW'(SETTLE);
  localparam logic [SW-1:0] TO_LAST   = SW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CUR_ONE   = CW'(1);
  localparam logic [RW-1:0] REF_ONE   = RW'(1);
  localparam logic [SW-1:0] S_ONE     = SW'(1);
  localparam logic [14:0]   MB_LAST   = 15'(MB_PER_FRAME - 1);
  localparam logic [13:0]   SAD_ABORT = 14'h3FFF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SEARCH = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_cnt_q, cur_cnt_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic          cur_read_q, cur_read_d;
  logic          ref_read_q, ref_read_d;
  logic          core_rst_n_q, core_rst_n_d;
  logic          res_valid_q, res_valid_d;
  logic [13:0]   res_sad_q, res_sad_d;
  logic [3:0]    res_x_q, res_x_d;
  logic [3:0]    res_y_q, res_y_d;
  logic [14:0]   mb_idx_q, mb_idx_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          timeout_err_q, timeout_err_d;

  logic          cur_xfer;
  logic          ref_xfer;

  assign cur_xfer = cur_read_q & cur_vld;
  assign ref_xfer = ref_read_q & ref_vld;

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    cur_cnt_d     = cur_cnt_q;
    ref_cnt_d     = ref_cnt_q;
    scnt_d        = scnt_q;
    res_sad_d     = res_sad_q;
    res_x_d       = res_x_q;
    res_y_d       = res_y_q;
    mb_idx_d      = mb_idx_q;
    timeout_err_d = timeout_err_q;
    frame_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d       = S_LOAD;
          mb_idx_d      = 15'd0;
          timeout_err_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        if (cur_xfer) begin
          cur_cnt_d = cur_cnt_q + CUR_ONE;
        end else begin
          cur_cnt_d = cur_cnt_q;
        end
        if (ref_xfer) begin
          ref_cnt_d = ref_cnt_q + REF_ONE;
        end else begin
          ref_cnt_d = ref_cnt_q;
        end
        if ((cur_cnt_d == CUR_FULL) && (ref_cnt_d == REF_FULL)) begin
          state_d   = S_SEARCH;
          cur_cnt_d = {CW{1'b0}};
          ref_cnt_d = {RW{1'b0}};
          scnt_d    = {SW{1'b0}};
        end else begin
          state_d = S_LOAD;
        end
      end

      // A real result on the final search cycle beats the abort
      S_SEARCH: begin
        if (sad_en && (scnt_q >= SETTLE_C)) begin
          res_sad_d = sad_min;
          res_x_d   = mv_x;
          res_y_d   = mv_y;
          scnt_d    = {SW{1'b0}};
          state_d   = S_OUTPUT;
        end else if (scnt_q == TO_LAST) begin
          res_sad_d     = SAD_ABORT;
          res_x_d       = 4'd0;
          res_y_d       = 4'd0;
          timeout_err_d = 1'b1;
          scnt_d        = {SW{1'b0}};
          state_d       = S_OUTPUT;
        end else begin
          scnt_d = scnt_q + S_ONE;
        end
      end

      S_OUTPUT: begin
        if (res_valid_q && res_ready) begin
          if (mb_idx_q == MB_LAST) begin
            mb_idx_d     = 15'd0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            mb_idx_d = mb_idx_q + 15'd1;
            state_d  = S_LOAD;
          end
        end else begin
          state_d = S_OUTPUT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes look at the post-transfer count so they never over-read
    cur_read_d   = (state_d == S_LOAD) && (cur_cnt_d < CUR_FULL);
    ref_read_d   = (state_d == S_LOAD) && (ref_cnt_d < REF_FULL);
    core_rst_n_d = (state_d == S_SEARCH);
    res_valid_d  = (state_d == S_OUTPUT);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cur_cnt_q     <= {CW{1'b0}};
      ref_cnt_q     <= {RW{1'b0}};
      scnt_q        <= {SW{1'b0}};
      cur_read_q    <= 1'b0;
      ref_read_q    <= 1'b0;
      core_rst_n_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_sad_q     <= 14'd0;
      res_x_q       <= 4'd0;
      res_y_q       <= 4'd0;
      mb_idx_q      <= 15'd0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_cnt_q     <= cur_cnt_d;
      ref_cnt_q     <= ref_cnt_d;
      scnt_q        <= scnt_d;
      cur_read_q    <= cur_read_d;
      ref_read_q    <= ref_read_d;
      core_rst_n_q  <= core_rst_n_d;
      res_valid_q   <= res_valid_d;
      res_sad_q     <= res_sad_d;
      res_x_q       <= res_x_d;
      res_y_q       <= res_y_d;
      mb_idx_q      <= mb_idx_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cur_read    = cur_read_q;
  assign ref_read    = ref_read_q;
  assign core_rst_n  = core_rst_n_q;
  assign res_valid   = res_valid_q;
  assign res_sad     = res_sad_q;
  assign res_x       = res_x_q;
  assign res_y       = res_y_q;
  assign mb_idx      = mb_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule
